// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite encodings, select indices and default-slave states
package ahb_pkg;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int SEL_S0  = 0;
  localparam int SEL_S1  = 1;
  localparam int SEL_S2  = 2;
  localparam int SEL_DEF = 3;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_t;

  // NONSEQ and SEQ are the only transfer types that demand a real response.
  function automatic logic trans_active(input logic [1:0] trans);
    return trans[1];
  endfunction

endpackage

// File: rtl/ahb_slave_mux_if.sv
// rtl/ahb_slave_mux_if.sv - decoder selects, slave responses and muxed master response
interface ahb_slave_mux_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  HSEL0;
  logic                  HSEL1;
  logic                  HSEL2;
  logic                  HSELd;
  logic [1:0]            HTRANS;
  logic [DATA_WIDTH-1:0] HRDATA0;
  logic [DATA_WIDTH-1:0] HRDATA1;
  logic [DATA_WIDTH-1:0] HRDATA2;
  logic                  HREADYOUT0;
  logic                  HREADYOUT1;
  logic                  HREADYOUT2;
  logic                  HRESP0;
  logic                  HRESP1;
  logic                  HRESP2;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADY;
  logic                  HRESP;

  modport slave (
    input  HSEL0, HSEL1, HSEL2, HSELd, HTRANS,
    input  HRDATA0, HRDATA1, HRDATA2,
    input  HREADYOUT0, HREADYOUT1, HREADYOUT2,
    input  HRESP0, HRESP1, HRESP2,
    output HRDATA, HREADY, HRESP
  );

  modport master (
    output HSEL0, HSEL1, HSEL2, HSELd, HTRANS,
    output HRDATA0, HRDATA1, HRDATA2,
    output HREADYOUT0, HREADYOUT1, HREADYOUT2,
    output HRESP0, HRESP1, HRESP2,
    input  HRDATA, HREADY, HRESP
  );

endinterface

// File: rtl/ahb_default_slave.sv
// rtl/ahb_default_slave.sv - answers unmapped active transfers with a two-cycle ERROR
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       HSEL,
  input  logic [1:0] HTRANS,
  input  logic       HREADY,
  output logic       HREADYOUT,
  output logic       HRESP
);

  ds_state_t state;
  logic      accept;

  assign accept = HSEL & HREADY & trans_active(HTRANS);

  // Outputs are loaded together with the next state so they are pure register outputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= DS_IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= HRESP_OKAY;
    end else begin
      case (state)
        DS_IDLE: begin
          if (accept) begin
            state     <= DS_ERR1;
            HREADYOUT <= 1'b0;
            HRESP     <= HRESP_ERROR;
          end
        end
        DS_ERR1: begin
          state     <= DS_ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= HRESP_ERROR;
        end
        DS_ERR2: begin
          if (accept) begin
            state     <= DS_ERR1;
            HREADYOUT <= 1'b0;
            HRESP     <= HRESP_ERROR;
          end else begin
            state     <= DS_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
          end
        end
        default: begin
          state     <= DS_IDLE;
          HREADYOUT <= 1'b1;
          HRESP     <= HRESP_OKAY;
        end
      endcase
    end
  end

endmodule

// File: rtl/ahb_slave_mux.sv
// rtl/ahb_slave_mux.sv - data-phase response mux with built-in default slave
module ahb_slave_mux
  import ahb_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int NO_OF_PERIPHERALS = 4
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  ahb_slave_mux_if.slave  bus
);

  logic [NO_OF_PERIPHERALS-1:0] sel_q;
  logic [NO_OF_PERIPHERALS-1:0] sel_d;
  logic                         hready;
  logic                         hresp;
  logic [DATA_WIDTH-1:0]        hrdata;
  logic                         ds_ready;
  logic                         ds_resp;

  assign sel_d = {bus.HSELd, bus.HSEL2, bus.HSEL1, bus.HSEL0};

  // Selects are only meaningful at an accepted address phase; wait states freeze them.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sel_q <= '0;
    end else if (hready) begin
      sel_q <= sel_d;
    end
  end

  ahb_default_slave u_default_slave (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (bus.HSELd),
    .HTRANS    (bus.HTRANS),
    .HREADY    (hready),
    .HREADYOUT (ds_ready),
    .HRESP     (ds_resp)
  );

  // Fixed priority 0 > 1 > 2 > default resolves illegal multi-hot captures.
  always_comb begin
    hready = 1'b1;
    hresp  = HRESP_OKAY;
    hrdata = '0;
    if (sel_q[SEL_S0]) begin
      hready = bus.HREADYOUT0;
      hresp  = bus.HRESP0;
      hrdata = bus.HRDATA0;
    end else if (sel_q[SEL_S1]) begin
      hready = bus.HREADYOUT1;
      hresp  = bus.HRESP1;
      hrdata = bus.HRDATA1;
    end else if (sel_q[SEL_S2]) begin
      hready = bus.HREADYOUT2;
      hresp  = bus.HRESP2;
      hrdata = bus.HRDATA2;
    end else if (sel_q[SEL_DEF]) begin
      hready = ds_ready;
      hresp  = ds_resp;
    end
  end

  assign bus.HREADY = hready;
  assign bus.HRESP  = hresp;
  assign bus.HRDATA = hrdata;

endmodule

// File: tb/tb_ahb_slave_mux.sv
// tb/tb_ahb_slave_mux.sv - self-checking bench for ahb_slave_mux
module tb_ahb_slave_mux;
  import ahb_pkg::*;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  // Reference model: owner of the current data phase (-1 none, 0..2 slaves, 3 default)
  // and how far into its two-cycle error answer the default slave is (0 none, 1, 2).
  int   m_cur = -1;
  int   m_dph = 0;

  always #5 clk = ~clk;

  ahb_slave_mux_if #(.DATA_WIDTH(DW)) bus ();

  ahb_slave_mux #(.DATA_WIDTH(DW), .NO_OF_PERIPHERALS(4)) dut (
    .HCLK    (clk),
    .HRESETn (rst_n),
    .bus     (bus.slave)
  );

  function automatic logic exp_ready();
    case (m_cur)
      0:       return bus.HREADYOUT0;
      1:       return bus.HREADYOUT1;
      2:       return bus.HREADYOUT2;
      3:       return (m_dph != 1);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic exp_resp();
    case (m_cur)
      0:       return bus.HRESP0;
      1:       return bus.HRESP1;
      2:       return bus.HRESP2;
      3:       return (m_dph != 0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [DW-1:0] exp_data();
    case (m_cur)
      0:       return bus.HRDATA0;
      1:       return bus.HRDATA1;
      2:       return bus.HRDATA2;
      default: return '0;
    endcase
  endfunction

  task automatic tick();
    logic       rdy;
    logic [3:0] s;
    logic [1:0] t;
    int         nc;
    rdy = exp_ready();
    s   = {bus.HSELd, bus.HSEL2, bus.HSEL1, bus.HSEL0};
    t   = bus.HTRANS;
    @(posedge clk);
    if (!rst_n) begin
      m_cur = -1;
      m_dph = 0;
    end else begin
      if (rdy) begin
        nc = -1;
        for (int i = 3; i >= 0; i--) if (s[i]) nc = i;
        m_cur = nc;
      end
      if (m_dph == 1) m_dph = 2;
      else m_dph = (rdy && s[3] && t[1]) ? 1 : 0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.HSEL0 = 0; bus.HSEL1 = 0; bus.HSEL2 = 0; bus.HSELd = 0;
    bus.HTRANS = TRANS_IDLE;
    bus.HRDATA0 = '0; bus.HRDATA1 = '0; bus.HRDATA2 = '0;
    bus.HREADYOUT0 = 1; bus.HREADYOUT1 = 1; bus.HREADYOUT2 = 1;
    bus.HRESP0 = 0; bus.HRESP1 = 0; bus.HRESP2 = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.HRDATA0 = 32'hFFFF_FFFF; bus.HRDATA1 = 32'hFFFF_FFFF; bus.HRDATA2 = 32'hFFFF_FFFF;
    bus.HREADYOUT0 = 0; bus.HREADYOUT1 = 0; bus.HREADYOUT2 = 0;
    #1 rst_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #2;
      checks++; if (bus.HREADY !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.HREADY); end
      checks++; if (bus.HRESP !== 1'b0) begin errors++; $display("FAIL reset_resp: got %b want 0", bus.HRESP); end
      checks++; if (bus.HRDATA !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", bus.HRDATA); end
      tick();
    end
    rst_n = 1'b1;
    tick();
    #2;
    checks++; if (bus.HREADY !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", bus.HREADY); end
    checks++; if (bus.HRESP !== 1'b0) begin errors++; $display("FAIL post_reset_resp: got %b want 0", bus.HRESP); end
    checks++; if (bus.HRDATA !== 32'h0) begin errors++; $display("FAIL post_reset_data: got %h want 0", bus.HRDATA); end
    tick();
  endtask

  task automatic test_read();
    idle_inputs();
    bus.HSEL1 = 1; bus.HTRANS = TRANS_NONSEQ;
    tick();
    idle_inputs();
    bus.HRDATA1 = 32'hDEAD_BEEF; bus.HREADYOUT1 = 1; bus.HRESP1 = 0;
    #2;
    checks++; if (bus.HRDATA !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_data: got %h want deadbeef", bus.HRDATA); end
    checks++; if (bus.HREADY !== 1'b1) begin errors++; $display("FAIL read_ready: got %b want 1", bus.HREADY); end
    checks++; if (bus.HRESP !== 1'b0) begin errors++; $display("FAIL read_resp: got %b want 0", bus.HRESP); end
    tick();
  endtask

  task automatic test_wait_hold();
    idle_inputs();
    bus.HSEL2 = 1; bus.HTRANS = TRANS_NONSEQ;
    tick();
    bus.HSEL2 = 0; bus.HSEL0 = 1;
    bus.HRDATA0 = 32'h1111_1111; bus.HRDATA2 = 32'h2222_2222;
    bus.HREADYOUT2 = 0;
    for (int c = 0; c < 2; c++) begin
      #2;
      checks++; if (bus.HREADY !== 1'b0) begin errors++; $display("FAIL wait_ready[%0d]: got %b want 0", c, bus.HREADY); end
      checks++; if (bus.HRDATA !== 32'h2222_2222) begin errors++; $display("FAIL wait_data[%0d]: got %h want 22222222", c, bus.HRDATA); end
      tick();
    end
    bus.HREADYOUT2 = 1;
    #2;
    checks++; if (bus.HREADY !== 1'b1 || bus.HRDATA !== 32'h2222_2222) begin
      errors++; $display("FAIL wait_release: got ready %b data %h want 1 22222222", bus.HREADY, bus.HRDATA);
    end
    tick();
    bus.HSEL0 = 0; bus.HTRANS = TRANS_IDLE;
    #2;
    checks++; if (bus.HRDATA !== 32'h1111_1111) begin errors++; $display("FAIL wait_next_sel: got %h want 11111111", bus.HRDATA); end
    tick();
  endtask

  task automatic test_default_error();
    idle_inputs();
    bus.HSELd = 1; bus.HTRANS = TRANS_NONSEQ;
    tick();
    idle_inputs();
    #2;
    checks++; if (bus.HREADY !== 1'b0 || bus.HRESP !== 1'b1) begin
      errors++; $display("FAIL dflt_err1: got ready %b resp %b want 0 1", bus.HREADY, bus.HRESP);
    end
    tick();
    #2;
    checks++; if (bus.HREADY !== 1'b1 || bus.HRESP !== 1'b1) begin
      errors++; $display("FAIL dflt_err2: got ready %b resp %b want 1 1", bus.HREADY, bus.HRESP);
    end
    tick();
    #2;
    checks++; if (bus.HREADY !== 1'b1 || bus.HRESP !== 1'b0) begin
      errors++; $display("FAIL dflt_done: got ready %b resp %b want 1 0", bus.HREADY, bus.HRESP);
    end
  endtask

  task automatic test_default_idle_busy();
    logic [1:0] types [2];
    types[0] = TRANS_IDLE;
    types[1] = TRANS_BUSY;
    idle_inputs();
    for (int k = 0; k < 2; k++) begin
      bus.HSELd = 1; bus.HTRANS = types[k];
      tick();
      #2;
      checks++; if (bus.HREADY !== 1'b1 || bus.HRESP !== 1'b0 || bus.HRDATA !== 32'h0) begin
        errors++; $display("FAIL dflt_nonactive[%0d]: got ready %b resp %b data %h want 1 0 0", k, bus.HREADY, bus.HRESP, bus.HRDATA);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    bus.HSELd = 1; bus.HTRANS = TRANS_NONSEQ;
    tick();
    idle_inputs();
    tick();
    bus.HSELd = 1; bus.HTRANS = TRANS_NONSEQ;
    #2;
    checks++; if (bus.HREADY !== 1'b1 || bus.HRESP !== 1'b1) begin
      errors++; $display("FAIL b2b_err2: got ready %b resp %b want 1 1", bus.HREADY, bus.HRESP);
    end
    tick();
    idle_inputs();
    #2;
    checks++; if (bus.HREADY !== 1'b0 || bus.HRESP !== 1'b1) begin
      errors++; $display("FAIL b2b_err1_again: got ready %b resp %b want 0 1", bus.HREADY, bus.HRESP);
    end
    tick();
    tick();
    #2;
    checks++; if (bus.HREADY !== 1'b1 || bus.HRESP !== 1'b0) begin
      errors++; $display("FAIL b2b_done: got ready %b resp %b want 1 0", bus.HREADY, bus.HRESP);
    end
  endtask

  task automatic test_reset_mid_error();
    idle_inputs();
    bus.HSELd = 1; bus.HTRANS = TRANS_NONSEQ;
    tick();
    idle_inputs();
    #2;
    checks++; if (bus.HREADY !== 1'b0 || bus.HRESP !== 1'b1) begin
      errors++; $display("FAIL rst_mid_err1: got ready %b resp %b want 0 1", bus.HREADY, bus.HRESP);
    end
    rst_n = 1'b0;
    m_cur = -1; m_dph = 0;
    #1;
    checks++; if (bus.HREADY !== 1'b1 || bus.HRESP !== 1'b0) begin
      errors++; $display("FAIL rst_mid_async: got ready %b resp %b want 1 0", bus.HREADY, bus.HRESP);
    end
    tick();
    rst_n = 1'b1;
    tick();
    #2;
    checks++; if (bus.HREADY !== 1'b1 || bus.HRESP !== 1'b0) begin
      errors++; $display("FAIL rst_mid_after: got ready %b resp %b want 1 0", bus.HREADY, bus.HRESP);
    end
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 600; c++) begin
      r = $urandom_range(0, 11);
      {bus.HSELd, bus.HSEL2, bus.HSEL1, bus.HSEL0} = 4'b0000;
      if (r >= 2 && r <= 5) bus.HSEL0 = (r == 2);
      if (r == 3) bus.HSEL1 = 1;
      if (r == 4) bus.HSEL2 = 1;
      if (r == 5 || r == 6 || r == 7) bus.HSELd = 1;
      if (r == 8) {bus.HSELd, bus.HSEL2, bus.HSEL1, bus.HSEL0} = 4'($urandom);
      bus.HTRANS     = 2'($urandom);
      bus.HRDATA0    = $urandom; bus.HRDATA1 = $urandom; bus.HRDATA2 = $urandom;
      bus.HREADYOUT0 = ($urandom_range(0, 3) != 0);
      bus.HREADYOUT1 = ($urandom_range(0, 3) != 0);
      bus.HREADYOUT2 = ($urandom_range(0, 3) != 0);
      bus.HRESP0 = 1'($urandom); bus.HRESP1 = 1'($urandom); bus.HRESP2 = 1'($urandom);
      #2;
      checks++; if (bus.HREADY !== exp_ready()) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, bus.HREADY, exp_ready()); end
      checks++; if (bus.HRESP !== exp_resp()) begin errors++; $display("FAIL rnd_resp[%0d]: got %b want %b", c, bus.HRESP, exp_resp()); end
      checks++; if (bus.HRDATA !== exp_data()) begin errors++; $display("FAIL rnd_data[%0d]: got %h want %h", c, bus.HRDATA, exp_data()); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_wait_hold();
    test_default_error();
    test_default_idle_busy();
    test_back_to_back();
    test_reset_mid_error();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
